// File: rtl/cripto_pkg.sv
// Shared width, rotate amount and round arithmetic for the cripto cipher.
package cripto_pkg;

  localparam int unsigned W   = 10;
  localparam int unsigned ROT = 3;

  // 10-bit left rotate; the amount wraps modulo the word width.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int unsigned n);
    logic [2*W-1:0] d;
    d = {x, x} << (n % W);
    return d[2*W-1 -: W];
  endfunction

  // Key schedule: round i uses the key rotated left by i.
  function automatic logic [W-1:0] round_key(input logic [W-1:0] key, input int unsigned i);
    return rotl(key, i);
  endfunction

  // One round: mix in the round key, rotate, add the round constant i+1 (mod 1024).
  function automatic logic [W-1:0] round_fn(input logic [W-1:0] s, input logic [W-1:0] rk,
                                            input int unsigned i);
    logic [W-1:0] t;
    t = s ^ rk;
    return rotl(t, ROT) + W'(i + 1);
  endfunction

endpackage

// File: rtl/cripto_round.sv
// One registered cipher round; the final stage also folds in output whitening.
module cripto_round
  import cripto_pkg::*;
#(
  parameter int unsigned IDX    = 0,
  parameter int unsigned ROUNDS = 4,
  parameter bit          LAST   = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         live_in,
  input  logic [W-1:0] state_in,
  input  logic [W-1:0] key_in,
  output logic         live_out,
  output logic [W-1:0] state_out,
  output logic [W-1:0] key_out
);

  logic [W-1:0] next_state;

  // Round arithmetic for this stage, plus whitening with rotl(key, ROUNDS) on the last one.
  always_comb begin
    next_state = round_fn(state_in, round_key(key_in, IDX), IDX);
    if (LAST) begin
      next_state = next_state ^ rotl(key_in, ROUNDS);
    end
  end

  // Stage register. The live flag marks a stage holding a real sample, so the
  // zeros left behind by reset drain to the output as zeros instead of being
  // pushed through the round arithmetic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_out  <= 1'b0;
      state_out <= '0;
      key_out   <= '0;
    end else begin
      live_out  <= live_in;
      state_out <= live_in ? next_state : '0;
      key_out   <= key_in;
    end
  end

endmodule

// File: rtl/cripto_cipher.sv
// Fully pipelined ROUNDS-round cipher: one round per stage, one pair per cycle.
module cripto_cipher
  import cripto_pkg::*;
#(
  parameter int unsigned ROUNDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] plaintext,
  input  logic [W-1:0] key,
  output logic [W-1:0] ciphertext
);

  logic [W-1:0] state_pipe [0:ROUNDS];
  logic [W-1:0] key_pipe   [0:ROUNDS];
  logic         live_pipe  [0:ROUNDS];

  assign state_pipe[0] = plaintext;
  assign key_pipe[0]   = key;
  assign live_pipe[0]  = 1'b1;

  // Chain of round stages; each carries its state alongside the key of the same sample.
  for (genvar g = 0; g < ROUNDS; g++) begin : g_round
    cripto_round #(
      .IDX    (g),
      .ROUNDS (ROUNDS),
      .LAST   (g == ROUNDS - 1)
    ) u_round (
      .clk       (clk),
      .reset     (reset),
      .live_in   (live_pipe[g]),
      .state_in  (state_pipe[g]),
      .key_in    (key_pipe[g]),
      .live_out  (live_pipe[g+1]),
      .state_out (state_pipe[g+1]),
      .key_out   (key_pipe[g+1])
    );
  end

  assign ciphertext = state_pipe[ROUNDS];

endmodule

// File: tb/tb_cripto_cipher.sv
// Directed and streaming checks for cripto_cipher at the default 4 rounds.
module tb_cripto_cipher;

  logic       clk;
  logic       reset;
  logic [9:0] plaintext;
  logic [9:0] key;
  logic [9:0] ciphertext;

  int errors = 0;
  int checks = 0;

  cripto_cipher #(.ROUNDS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .plaintext  (plaintext),
    .key        (key),
    .ciphertext (ciphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: bit-by-bit rotate, independent of the design package.
  function automatic logic [9:0] m_rotl(input logic [9:0] x, input int n);
    logic [9:0] r;
    r = '0;
    for (int b = 0; b < 10; b++) r[(b + n) % 10] = x[b];
    return r;
  endfunction

  function automatic logic [9:0] model(input logic [9:0] p, input logic [9:0] k);
    logic [9:0] s;
    s = p;
    for (int i = 0; i < 4; i++) s = m_rotl(s ^ m_rotl(k, i), 3) + 10'(i + 1);
    return s ^ m_rotl(k, 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // New random pair every cycle; output after each edge is the pair from 3 iterations earlier.
  task automatic run_stream(input int n, input string tag);
    logic [9:0] ph[$];
    logic [9:0] kh[$];
    for (int j = 0; j < n; j++) begin
      plaintext = 10'($urandom);
      key       = 10'($urandom);
      ph.push_back(plaintext);
      kh.push_back(key);
      tick();
      if (j >= 3) check(tag, ciphertext, model(ph[j-3], kh[j-3]));
    end
  endtask

  initial begin
    logic [9:0] ph[$];
    logic [9:0] kh[$];
    bit         seen [0:1023];
    int         distinct;

    reset     = 1'b0;
    plaintext = '0;
    key       = '0;
    #1;
    check("reset_now", ciphertext, 10'h000);
    repeat (2) tick();
    check("reset_hold", ciphertext, 10'h000);

    // Release, zero inputs: 0 for three edges, 0x29C from the fourth.
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("post_release_zero", ciphertext, 10'h000);
    end
    tick();
    check("zero_vec_4th", ciphertext, 10'h29C);
    repeat (3) begin
      tick();
      check("zero_vec_steady", ciphertext, 10'h29C);
    end

    // Latency step to key=0x3FF (exercises the round-0 wrap).
    key = 10'h3FF;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("step_old", ciphertext, 10'h29C);
    end
    tick();
    check("step_new", ciphertext, 10'h3D3);
    repeat (2) begin
      tick();
      check("ones_key_steady", ciphertext, 10'h3D3);
    end

    run_stream(200, "stream");

    // Reset mid-stream: zero at once, in-flight data discarded.
    run_stream(20, "stream_pre_rst");
    #2;
    reset = 1'b0;
    #1;
    check("midrst_now", ciphertext, 10'h000);
    plaintext = 10'h1A5;
    key       = 10'h2C3;
    repeat (2) begin
      tick();
      check("midrst_hold", ciphertext, 10'h000);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 12; j++) begin
      plaintext = 10'($urandom);
      key       = 10'($urandom);
      ph.push_back(plaintext);
      kh.push_back(key);
      tick();
      if (j < 3) check("midrst_bubble", ciphertext, 10'h000);
      else       check("midrst_data", ciphertext, model(ph[j-3], kh[j-3]));
    end

    // Bijectivity sweep for key=0x155.
    for (int v = 0; v < 1024; v++) seen[v] = 1'b0;
    distinct = 0;
    key = 10'h155;
    for (int j = 0; j < 1027; j++) begin
      plaintext = (j < 1024) ? 10'(j) : 10'h000;
      tick();
      if (j >= 3) begin
        check("sweep", ciphertext, model(10'(j - 3), 10'h155));
        if (!seen[ciphertext]) begin
          seen[ciphertext] = 1'b1;
          distinct++;
        end
      end
    end
    check("bijective", distinct, 1024);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cripto_cipher.md
CRIPTO_CIPHER -- requirements
Module: cripto_cipher

Interface
REQ-001 Parameter ROUNDS, default 4, number of cipher rounds and pipeline stages; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 plaintext  input  10  data word to encrypt; sampled every rising edge.
REQ-005 key  input  10  cipher key; sampled every rising edge together with plaintext.
REQ-006 ciphertext  output  10  registered encrypted word.

Function
REQ-007 Definitions: rotl(x,n) is a 10-bit left rotate; all additions are mod 1024 (carry out discarded).
REQ-008 Round key: rk_i = rotl(key, i) for i = 0..ROUNDS-1.
REQ-009 Round constant: RC_i = i+1, zero-extended to 10 bits.
REQ-010 Round i: t = s ^ rk_i, then s' = rotl(t,3) + RC_i; s0 = plaintext.
REQ-011 Output whitening: ciphertext = s_ROUNDS ^ rotl(key, ROUNDS).
REQ-012 Pipelining: one round per stage, with one register stage per round; each stage carries its state and the key of the same sample.
REQ-013 Whitening is combinational into the last stage register, and that register drives ciphertext.
REQ-014 Latency: a plaintext/key pair present before edge N appears on ciphertext after edge N+ROUNDS-1 (4 edges for the default).
REQ-015 Throughput: one new pair is accepted per cycle; outputs appear in input order with no bubbles.
REQ-016 Constant inputs give a constant ciphertext after the latency; no handshake, valid or stall signals exist.
REQ-017 plaintext and key change independently; each pair is processed as sampled on the same edge.
REQ-018 For a fixed key the mapping plaintext->ciphertext is a bijection on 0..1023.

Reset
REQ-019 While reset=0, all stage registers and ciphertext are 0, asynchronously and immediately.
REQ-020 Reset asserted mid-operation discards all in-flight samples.
REQ-021 After release, ciphertext is 0 until the first sampled pair reaches the output per REQ-014.
REQ-022 No other storage exists; no initial blocks are relied on for reset values.

Structure
REQ-023 A shared package cripto_pkg holds the following items:
- width constant W=10;
- rotate amount 3;
- function rotl;
- function round_fn(s, rk, i) implementing REQ-010;
- function round_key(key, i).
REQ-024 One sub-module, cripto_round, implements a single registered stage: state/key in, state/key out, with clk/reset.
REQ-025 The top generates ROUNDS instances of cripto_round, and the last stage applies whitening.

Verification
REQ-026 key=0x000, plaintext=0x000 held -> ciphertext=0x29C from the 4th edge onward.
REQ-027 key=0x3FF, plaintext=0x000 held -> ciphertext=0x3D3, which exercises the mod-1024 wrap in round 0.
REQ-028 Latency step test:
- hold the REQ-026 inputs until steady;
- switch to key=0x3FF, plaintext=0x000;
- required: 0x29C persists for 3 edges, then 0x3D3 on the 4th edge.
REQ-029 Streaming test:
- apply a new random pair every cycle for 200 cycles;
- required: each output matches a bench reference model delayed 4 cycles, with none dropped or reordered.
REQ-030 Reset mid-stream:
- assert reset during streaming;
- required: ciphertext=0 at once and for 3 edges after release, then results for pairs sampled only after release.
REQ-031 Bijectivity: for key=0x155, sweep all 1024 plaintexts -> 1024 distinct ciphertexts.
